// File: rtl/serial_digit_pkg.sv
// rtl/serial_digit_pkg.sv - shared types and helpers for the serial digit checker
//
// Purpose: FSM state encoding, constant clog2 helper and default parameter
// values used by serial_digit_checker and serial_digit_shreg.
// Ports: none (package).
package serial_digit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WORD_W  = 4;
  localparam int DEF_MAX_VAL = 9;

  // Ceiling log2, usable in constant expressions; clog2(4)=2, clog2(5)=3.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_digit_shreg.sv
// rtl/serial_digit_shreg.sv - direction-selectable shift register with bit counter
//
// Purpose: assembles a WORD_W-bit word one accepted bit at a time and
// strobes done on the cycle that accepts the last bit.
// Ports:
//   clock      in   rising-edge clock
//   nRESET_G   in   asynchronous active-low reset
//   clr        in   synchronous clear of shift register and counter
//   shift_en   in   accept bit_in this cycle
//   bit_in     in   serial data bit
//   word_next  out  word as it will be after accepting bit_in (combinational)
//   done       out  shift_en on the last bit of the word (combinational)
module serial_digit_shreg
  import serial_digit_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              nRESET_G,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word_next,
  output logic              done
);

  localparam int                CNT_W = clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  // The comparator downstream needs the word including the bit being
  // accepted now, so the next value is exposed rather than sreg itself.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next = {sreg[WORD_W-2:0], bit_in};
    end else begin : g_lsb
      assign word_next = {bit_in, sreg[WORD_W-1:1]};
    end
  endgenerate

  assign done = shift_en && (cnt == LAST);

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= word_next;
      // Return to zero on the last bit so the count never passes WORD_W-1.
      cnt  <= done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_digit_checker.sv
// rtl/serial_digit_checker.sv - start-bit framed serial word range checker
//
// Purpose: frames a WORD_W-bit word after a START_LVL start bit on LINEA,
// compares it unsigned against MAX_VAL and pulses U_REG (in range) or
// U_ERR (out of range) one cycle after the last bit, presenting the word
// on DIGIT_OUT until the next completed word.
// Optional build macro SERIAL_DIGIT_ERR_CNT_EN adds ERR_CNT, a saturating
// count of U_ERR pulses cleared by reset and SYNC_CLR.
// Ports:
//   clock      in   rising-edge clock
//   nRESET_G   in   asynchronous active-low reset
//   LINEA      in   serial data bit
//   LINEA_VLD  in   LINEA is sampled only when high
//   SYNC_CLR   in   synchronous framing abort, highest priority
//   U_REG      out  one-cycle pulse: word <= MAX_VAL
//   U_ERR      out  one-cycle pulse: word >  MAX_VAL
//   ERR_CNT    out  [7:0] saturating U_ERR count (macro builds only)
//   DIGIT_OUT  out  [WORD_W-1:0] last completed word
module serial_digit_checker
  import serial_digit_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MAX_VAL   = DEF_MAX_VAL,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit START_LVL = 1'b1
) (
  input  logic              clock,
  input  logic              nRESET_G,
  input  logic              LINEA,
  input  logic              LINEA_VLD,
  input  logic              SYNC_CLR,
  output logic              U_REG,
  output logic              U_ERR,
`ifdef SERIAL_DIGIT_ERR_CNT_EN
  output logic [7:0]        ERR_CNT,
`endif
  output logic [WORD_W-1:0] DIGIT_OUT
);

  localparam logic [WORD_W-1:0] MAX_W = WORD_W'(MAX_VAL);

  state_t            state;
  logic              start;
  logic              accept;
  logic              done;
  logic              word_bad;
  logic [WORD_W-1:0] word_next;

  assign start    = (state == IDLE) && LINEA_VLD && (LINEA == START_LVL) && !SYNC_CLR;
  assign accept   = (state == SHIFT) && LINEA_VLD && !SYNC_CLR;
  assign word_bad = (word_next > MAX_W);

  // Clearing on the start bit makes every word begin from a known register
  // and counter, independent of how the previous word ended.
  serial_digit_shreg #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clock     (clock),
    .nRESET_G  (nRESET_G),
    .clr       (SYNC_CLR | start),
    .shift_en  (accept),
    .bit_in    (LINEA),
    .word_next (word_next),
    .done      (done)
  );

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state     <= IDLE;
      U_REG     <= 1'b0;
      U_ERR     <= 1'b0;
      DIGIT_OUT <= '0;
    end else begin
      U_REG <= 1'b0;
      U_ERR <= 1'b0;
      if (SYNC_CLR) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) state <= SHIFT;
          end
          SHIFT: begin
            if (done) begin
              state     <= IDLE;
              DIGIT_OUT <= word_next;
              U_REG     <= !word_bad;
              U_ERR     <= word_bad;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SERIAL_DIGIT_ERR_CNT_EN
  // done already excludes SYNC_CLR cycles, so this increments on exactly
  // the edges that raise U_ERR.
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      ERR_CNT <= 8'd0;
    end else if (SYNC_CLR) begin
      ERR_CNT <= 8'd0;
    end else if (done && word_bad && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_digit_checker.sv
// tb/tb_serial_digit_checker.sv - self-checking bench for serial_digit_checker
//
// Purpose: table-driven words plus hand-written corner sequences, with
// expected completions queued at stimulus time and compared when the DUT
// pulses. A second instance runs in LSB-first mode.
// Optional build macro SERIAL_DIGIT_ERR_CNT_EN enables the ERR_CNT checks.
// Ports: none (top-level bench).
module tb_serial_digit_checker;

  logic       clock = 1'b0;
  logic       nRESET_G;
  logic       LINEA;
  logic       LINEA_VLD;
  logic       SYNC_CLR;
  logic       u_reg, u_err, l_reg, l_err;
  logic [3:0] digit, l_digit;
`ifdef SERIAL_DIGIT_ERR_CNT_EN
  logic [7:0] err_cnt, l_err_cnt;
`endif

  always #5 clock = ~clock;

  serial_digit_checker #(
    .WORD_W(4), .MAX_VAL(9), .MSB_FIRST(1'b1), .START_LVL(1'b1)
  ) dut (
    .clock     (clock),
    .nRESET_G  (nRESET_G),
    .LINEA     (LINEA),
    .LINEA_VLD (LINEA_VLD),
    .SYNC_CLR  (SYNC_CLR),
    .U_REG     (u_reg),
    .U_ERR     (u_err),
`ifdef SERIAL_DIGIT_ERR_CNT_EN
    .ERR_CNT   (err_cnt),
`endif
    .DIGIT_OUT (digit)
  );

  serial_digit_checker #(
    .WORD_W(4), .MAX_VAL(9), .MSB_FIRST(1'b0), .START_LVL(1'b1)
  ) dut_lsb (
    .clock     (clock),
    .nRESET_G  (nRESET_G),
    .LINEA     (LINEA),
    .LINEA_VLD (LINEA_VLD),
    .SYNC_CLR  (SYNC_CLR),
    .U_REG     (l_reg),
    .U_ERR     (l_err),
`ifdef SERIAL_DIGIT_ERR_CNT_EN
    .ERR_CNT   (l_err_cnt),
`endif
    .DIGIT_OUT (l_digit)
  );

  typedef struct packed {
    logic       r;
    logic       e;
    logic [3:0] d;
    logic [7:0] c;
  } exp_t;

  typedef struct {
    logic [3:0] v;
    logic       r;
    logic       e;
    logic [3:0] d;
  } vec_t;

  exp_t q[$];
  exp_t ql[$];
  exp_t em;
  exp_t el;
  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;
  int   err_pulses = 0;
  bit   chk_lsb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic r, input logic e, input logic [3:0] d);
    exp_t x;
    if (e && model_cnt < 255) model_cnt++;
    x.r = r;
    x.e = e;
    x.d = d;
    x.c = 8'(model_cnt);
    return x;
  endfunction

  // Scoreboard side: every completion pulse must match the oldest queued entry.
  always @(negedge clock) begin
    if (nRESET_G === 1'b1) begin
      if (u_reg || u_err) begin
        if (u_err) err_pulses++;
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'(1), 32'(0));
        end else begin
          em = q.pop_front();
          check("flags", 32'({u_reg, u_err}), 32'({em.r, em.e}));
          check("digit", 32'(digit), 32'(em.d));
`ifdef SERIAL_DIGIT_ERR_CNT_EN
          if (u_err) check("err_cnt", 32'(err_cnt), 32'(em.c));
`endif
        end
      end
      if (chk_lsb && (l_reg || l_err)) begin
        if (ql.size() == 0) begin
          check("lsb_unexpected_pulse", 32'(1), 32'(0));
        end else begin
          el = ql.pop_front();
          check("lsb_flags", 32'({l_reg, l_err}), 32'({el.r, el.e}));
          check("lsb_digit", 32'(l_digit), 32'(el.d));
        end
      end
    end
  end

  task automatic cyc(input logic vld, input logic lin, input logic clr);
    LINEA_VLD = vld;
    LINEA     = lin;
    SYNC_CLR  = clr;
    @(posedge clock);
    #1;
  endtask

  // Start bit followed by four data bits, MSB first; the expectation is
  // queued just before the last bit is presented.
  task automatic send_word(input logic [3:0] v, input exp_t ex);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) q.push_back(ex);
      cyc(1'b1, v[i], 1'b0);
    end
  endtask

  task automatic check_drained(input string name);
    cyc(1'b0, 1'b0, 1'b0);
    check(name, 32'(q.size()), 32'(0));
  endtask

  vec_t tab[6];
  int   p0;

  initial begin
    tab[0] = '{v: 4'd11, r: 1'b0, e: 1'b1, d: 4'hB};
    tab[1] = '{v: 4'd9,  r: 1'b1, e: 1'b0, d: 4'h9};
    tab[2] = '{v: 4'd0,  r: 1'b1, e: 1'b0, d: 4'h0};
    tab[3] = '{v: 4'd15, r: 1'b0, e: 1'b1, d: 4'hF};
    tab[4] = '{v: 4'd10, r: 1'b0, e: 1'b1, d: 4'hA};
    tab[5] = '{v: 4'd8,  r: 1'b1, e: 1'b0, d: 4'h8};

    nRESET_G  = 1'b0;
    LINEA     = 1'b0;
    LINEA_VLD = 1'b0;
    SYNC_CLR  = 1'b0;
    #12;
    check("rst_u_reg", 32'(u_reg), 32'(0));
    check("rst_u_err", 32'(u_err), 32'(0));
    check("rst_digit", 32'(digit), 32'(0));
`ifdef SERIAL_DIGIT_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    #1 nRESET_G = 1'b1;
    @(posedge clock);
    #1;
    cyc(1'b0, 1'b0, 1'b0);

    // Valid digit 0111.
    send_word(4'd7, mk(1'b1, 1'b0, 4'h7));
    check_drained("drain_valid");

    // Table words sent back to back (11 then 9 leads the table).
    for (int i = 0; i < 6; i++) begin
      send_word(tab[i].v, mk(tab[i].r, tab[i].e, tab[i].d));
    end
    check_drained("drain_table");

    // Asynchronous reset mid-word.
    send_word(4'd5, mk(1'b1, 1'b0, 4'h5));
    check_drained("drain_pre_reset");
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    #3 nRESET_G = 1'b0;
    #1;
    check("async_rst_u_reg", 32'(u_reg), 32'(0));
    check("async_rst_u_err", 32'(u_err), 32'(0));
    check("async_rst_digit", 32'(digit), 32'(0));
    model_cnt = 0;
    #2 nRESET_G = 1'b1;
    @(posedge clock);
    #1;
    send_word(4'd6, mk(1'b1, 1'b0, 4'h6));
    check_drained("drain_post_reset");

    // LSB-first instance with stalls; garbage on LINEA while VLD=0.
    chk_lsb = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    q.push_back(mk(1'b1, 1'b0, 4'h8));
    ql.push_back(mk(1'b1, 1'b0, 4'h1));
    cyc(1'b1, 1'b0, 1'b0);
    check_drained("drain_stall_msb");
    check("drain_stall_lsb", 32'(ql.size()), 32'(0));
    chk_lsb = 1'b0;

    // SYNC_CLR on the last-bit cycle discards the word.
    send_word(4'd3, mk(1'b1, 1'b0, 4'h3));
    check_drained("drain_pre_clr");
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    model_cnt = 0;
    check_drained("drain_clr");
    check("clr_digit_held", 32'(digit), 32'(3));
    send_word(4'd0, mk(1'b1, 1'b0, 4'h0));
    check_drained("drain_post_clr");

`ifdef SERIAL_DIGIT_ERR_CNT_EN
    cyc(1'b0, 1'b0, 1'b1);
    model_cnt = 0;
    cyc(1'b0, 1'b0, 1'b0);
    p0 = err_pulses;
    for (int i = 0; i < 260; i++) begin
      send_word(4'd15, mk(1'b0, 1'b1, 4'hF));
    end
    check_drained("drain_sat");
    check("err_cnt_sat", 32'(err_cnt), 32'(255));
    check("err_pulse_count", 32'(err_pulses - p0), 32'(260));
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("err_cnt_clr", 32'(err_cnt), 32'(0));
`endif

    check("queue_empty", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
